// File: rtl/core_pkg.sv
// Shared core types: issue-queue entry layout, default sizes and the writeback tag-match helper.
package core_pkg;

  localparam int IQ_DEPTH     = 16;
  localparam int IQ_PREG_W    = 6;
  localparam int IQ_AL_W      = 6;
  localparam int IQ_PAYLOAD_W = 96;
  localparam int IQ_WB_PORTS  = 4;

  typedef struct packed {
    logic                    valid;
    logic                    rs1_rdy;
    logic                    rs2_rdy;
    logic [IQ_PREG_W-1:0]    rd;
    logic [IQ_PREG_W-1:0]    rs1;
    logic [IQ_PREG_W-1:0]    rs2;
    logic [IQ_AL_W-1:0]      al_addr;
    logic [IQ_PAYLOAD_W-1:0] payload;
  } iq_entry_t;

  // True when any writeback port that actually writes a register broadcasts this tag.
  function automatic logic wb_hit(
    input logic [IQ_PREG_W-1:0]                  tag,
    input logic [IQ_WB_PORTS-1:0]                wb_valid,
    input logic [IQ_WB_PORTS-1:0]                wb_uses_rd,
    input logic [IQ_WB_PORTS-1:0][IQ_PREG_W-1:0] wb_rd
  );
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < IQ_WB_PORTS; p++) begin
      if (wb_valid[p] && wb_uses_rd[p] && (wb_rd[p] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/int_issue_queue_age_select.sv
// Oldest-first two-way select: age[i][j]=1 means entry i is older than entry j.
module iq_age_select #(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0]            ready,
  input  logic [DEPTH-1:0][DEPTH-1:0] age,
  output logic [DEPTH-1:0]            gnt0,
  output logic                        gnt0_vld,
  output logic [DEPTH-1:0]            gnt1,
  output logic                        gnt1_vld
);

  logic [DEPTH-1:0] ready_rest;

  // An entry wins when no other ready entry is older than it.
  always_comb begin
    gnt0 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      gnt0[i] = ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (ready[j] && age[j][i]) gnt0[i] = 1'b0;
      end
    end
  end

  assign ready_rest = ready & ~gnt0;

  always_comb begin
    gnt1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      gnt1[i] = ready_rest[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (ready_rest[j] && age[j][i]) gnt1[i] = 1'b0;
      end
    end
  end

  assign gnt0_vld = |gnt0;
  assign gnt1_vld = |gnt1;

endmodule

// File: rtl/int_issue_queue.sv
// Integer issue queue: 2-wide dispatch, 4-port wakeup, 2-wide oldest-first issue.
// Optional IQ_PERF_CNT_EN adds stall-cycle and issue-count counters.
module int_issue_queue
  import core_pkg::*;
#(
  parameter int DEPTH     = IQ_DEPTH,
  parameter int PREG_W    = IQ_PREG_W,
  parameter int AL_W      = IQ_AL_W,
  parameter int PAYLOAD_W = IQ_PAYLOAD_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_flush,
  input  logic [1:0]                i_disp_valid,
  input  logic [1:0][PREG_W-1:0]    i_disp_rd,
  input  logic [1:0][PREG_W-1:0]    i_disp_rs1,
  input  logic [1:0][PREG_W-1:0]    i_disp_rs2,
  input  logic [1:0]                i_disp_uses_rs1,
  input  logic [1:0]                i_disp_uses_rs2,
  input  logic [1:0]                i_disp_rs1_rdy,
  input  logic [1:0]                i_disp_rs2_rdy,
  input  logic [1:0][AL_W-1:0]      i_disp_al_addr,
  input  logic [1:0][PAYLOAD_W-1:0] i_disp_payload,
  output logic                      o_stall,
  input  logic [3:0]                i_wb_valid,
  input  logic [3:0]                i_wb_uses_rd,
  input  logic [3:0][PREG_W-1:0]    i_wb_rd,
  output logic [1:0]                o_iss_valid,
  output logic [1:0][PREG_W-1:0]    o_iss_rd,
  output logic [1:0][PREG_W-1:0]    o_iss_rs1,
  output logic [1:0][PREG_W-1:0]    o_iss_rs2,
  output logic [1:0][AL_W-1:0]      o_iss_al_addr,
  output logic [1:0][PAYLOAD_W-1:0] o_iss_payload,
  input  logic [1:0]                i_iss_ready
`ifdef IQ_PERF_CNT_EN
  ,
  output logic [31:0]               o_stall_cycles,
  output logic [31:0]               o_issue_count
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  iq_entry_t                  q [DEPTH];
  iq_entry_t                  new_e [2];
  logic [DEPTH-1:0]           valid_vec, ready_vec, wake1, wake2;
  logic [DEPTH-1:0][DEPTH-1:0] age;
  logic [1:0][DEPTH-1:0]      gnt;
  logic [1:0]                 gnt_vld, disp_en, hs;
  logic [DEPTH-1:0]           alloc0, alloc1, wr0, wr1, iss_free;
  logic [CNT_W-1:0]           valid_cnt;

  function automatic logic [DEPTH-1:0] lowest_one(input logic [DEPTH-1:0] v);
    return v & (~v + DEPTH'(1));
  endfunction

  always_comb begin
    valid_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = q[i].valid;
      ready_vec[i] = q[i].valid & q[i].rs1_rdy & q[i].rs2_rdy;
      wake1[i]     = wb_hit(q[i].rs1, i_wb_valid, i_wb_uses_rd, i_wb_rd);
      wake2[i]     = wb_hit(q[i].rs2, i_wb_valid, i_wb_uses_rd, i_wb_rd);
      valid_cnt    = valid_cnt + CNT_W'(q[i].valid);
    end
  end

  // Frees from this cycle's issue are deliberately not counted here.
  assign o_stall = (CNT_W'(DEPTH) - valid_cnt) < CNT_W'(2);
  assign disp_en = i_disp_valid & {2{~o_stall}};

  // Slot 1 packs into the lowest free entry when slot 0 is idle.
  assign alloc0 = lowest_one(~valid_vec);
  assign alloc1 = disp_en[0] ? lowest_one(~valid_vec & ~alloc0) : alloc0;
  assign wr0    = alloc0 & {DEPTH{disp_en[0]}};
  assign wr1    = alloc1 & {DEPTH{disp_en[1]}};

  // Incoming sources also see same-cycle writebacks so they never miss a wakeup.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      new_e[s].valid   = 1'b1;
      new_e[s].rs1_rdy = !i_disp_uses_rs1[s] || i_disp_rs1_rdy[s] ||
                         wb_hit(i_disp_rs1[s], i_wb_valid, i_wb_uses_rd, i_wb_rd);
      new_e[s].rs2_rdy = !i_disp_uses_rs2[s] || i_disp_rs2_rdy[s] ||
                         wb_hit(i_disp_rs2[s], i_wb_valid, i_wb_uses_rd, i_wb_rd);
      new_e[s].rd      = i_disp_rd[s];
      new_e[s].rs1     = i_disp_rs1[s];
      new_e[s].rs2     = i_disp_rs2[s];
      new_e[s].al_addr = i_disp_al_addr[s];
      new_e[s].payload = i_disp_payload[s];
    end
  end

  iq_age_select #(.DEPTH(DEPTH)) u_select (
    .ready    (ready_vec),
    .age      (age),
    .gnt0     (gnt[0]),
    .gnt0_vld (gnt_vld[0]),
    .gnt1     (gnt[1]),
    .gnt1_vld (gnt_vld[1])
  );

  assign o_iss_valid = gnt_vld;
  assign hs          = o_iss_valid & i_iss_ready;
  assign iss_free    = (gnt[0] & {DEPTH{hs[0]}}) | (gnt[1] & {DEPTH{hs[1]}});

  always_comb begin
    o_iss_rd      = '0;
    o_iss_rs1     = '0;
    o_iss_rs2     = '0;
    o_iss_al_addr = '0;
    o_iss_payload = '0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (gnt[k][i]) begin
          o_iss_rd[k]      = q[i].rd;
          o_iss_rs1[k]     = q[i].rs1;
          o_iss_rs2[k]     = q[i].rs2;
          o_iss_al_addr[k] = q[i].al_addr;
          o_iss_payload[k] = q[i].payload;
        end
      end
    end
  end

  // Entry state: only valid bits and the age matrix are cleared.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
      age <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr0[i]) begin
          q[i] <= new_e[0];
        end else if (wr1[i]) begin
          q[i] <= new_e[1];
        end else if (q[i].valid) begin
          if (wake1[i])    q[i].rs1_rdy <= 1'b1;
          if (wake2[i])    q[i].rs2_rdy <= 1'b1;
          if (iss_free[i]) q[i].valid   <= 1'b0;
        end
      end
      // New entry is younger than every live entry; slot 1 is also younger than slot 0.
      for (int n = 0; n < DEPTH; n++) begin
        if (wr0[n]) begin
          for (int j = 0; j < DEPTH; j++) age[j][n] <= valid_vec[j];
          age[n] <= '0;
        end
      end
      for (int n = 0; n < DEPTH; n++) begin
        if (wr1[n]) begin
          for (int j = 0; j < DEPTH; j++) age[j][n] <= valid_vec[j] | wr0[j];
          age[n] <= '0;
        end
      end
    end
  end

`ifdef IQ_PERF_CNT_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_stall_cycles <= '0;
      o_issue_count  <= '0;
    end else begin
      o_stall_cycles <= o_stall_cycles + 32'(o_stall);
      o_issue_count  <= o_issue_count + 32'(hs[0]) + 32'(hs[1]);
    end
  end
`endif

endmodule

// File: tb/tb_int_issue_queue.sv
// Directed bench for int_issue_queue: per-cycle vector table plus fill and flush sequences.
module tb_int_issue_queue;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_flush;
  logic [1:0]       i_disp_valid;
  logic [1:0][5:0]  i_disp_rd, i_disp_rs1, i_disp_rs2;
  logic [1:0]       i_disp_uses_rs1, i_disp_uses_rs2, i_disp_rs1_rdy, i_disp_rs2_rdy;
  logic [1:0][5:0]  i_disp_al_addr;
  logic [1:0][95:0] i_disp_payload;
  logic             o_stall;
  logic [3:0]       i_wb_valid, i_wb_uses_rd;
  logic [3:0][5:0]  i_wb_rd;
  logic [1:0]       o_iss_valid;
  logic [1:0][5:0]  o_iss_rd, o_iss_rs1, o_iss_rs2, o_iss_al_addr;
  logic [1:0][95:0] o_iss_payload;
  logic [1:0]       i_iss_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  int_issue_queue dut (
    .clk             (clk),
    .reset           (reset),
    .i_flush         (i_flush),
    .i_disp_valid    (i_disp_valid),
    .i_disp_rd       (i_disp_rd),
    .i_disp_rs1      (i_disp_rs1),
    .i_disp_rs2      (i_disp_rs2),
    .i_disp_uses_rs1 (i_disp_uses_rs1),
    .i_disp_uses_rs2 (i_disp_uses_rs2),
    .i_disp_rs1_rdy  (i_disp_rs1_rdy),
    .i_disp_rs2_rdy  (i_disp_rs2_rdy),
    .i_disp_al_addr  (i_disp_al_addr),
    .i_disp_payload  (i_disp_payload),
    .o_stall         (o_stall),
    .i_wb_valid      (i_wb_valid),
    .i_wb_uses_rd    (i_wb_uses_rd),
    .i_wb_rd         (i_wb_rd),
    .o_iss_valid     (o_iss_valid),
    .o_iss_rd        (o_iss_rd),
    .o_iss_rs1       (o_iss_rs1),
    .o_iss_rs2       (o_iss_rs2),
    .o_iss_al_addr   (o_iss_al_addr),
    .o_iss_payload   (o_iss_payload),
    .i_iss_ready     (i_iss_ready)
  );

  typedef struct {
    logic [1:0] dv;
    logic [5:0] t1a; logic r1a;
    logic [5:0] t1b; logic r1b;
    logic [5:0] t2;  logic r2;
    logic [5:0] al0, al1;
    logic [3:0] wbv, wbu; logic [5:0] wbrd;
    logic [1:0] irdy;
    logic [1:0] eiv; logic est;
    logic [5:0] eal0, eal1;
  } vec_t;

  vec_t tv [$];

  function automatic vec_t mk(logic [1:0] dv, logic [5:0] t1a, logic r1a, logic [5:0] t1b, logic r1b,
                              logic [5:0] t2, logic r2, logic [5:0] al0, logic [5:0] al1,
                              logic [3:0] wbv, logic [3:0] wbu, logic [5:0] wbrd, logic [1:0] irdy,
                              logic [1:0] eiv, logic est, logic [5:0] eal0, logic [5:0] eal1);
    vec_t v;
    v.dv = dv; v.t1a = t1a; v.r1a = r1a; v.t1b = t1b; v.r1b = r1b; v.t2 = t2; v.r2 = r2;
    v.al0 = al0; v.al1 = al1; v.wbv = wbv; v.wbu = wbu; v.wbrd = wbrd; v.irdy = irdy;
    v.eiv = eiv; v.est = est; v.eal0 = eal0; v.eal1 = eal1;
    return v;
  endfunction

  task automatic idle();
    i_flush = 1'b0; i_disp_valid = '0; i_disp_rd = '0; i_disp_rs1 = '0; i_disp_rs2 = '0;
    i_disp_uses_rs1 = '0; i_disp_uses_rs2 = '0; i_disp_rs1_rdy = '0; i_disp_rs2_rdy = '0;
    i_disp_al_addr = '0; i_disp_payload = '0; i_wb_valid = '0; i_wb_uses_rd = '0;
    i_wb_rd = '0; i_iss_ready = '0;
  endtask

  // rd and payload are derived from al so every issued field can be checked from one number.
  task automatic set_slot(int s, logic [5:0] al, logic [5:0] t1, logic rdy1, logic [5:0] t2, logic rdy2);
    i_disp_valid[s] = 1'b1;
    i_disp_rd[s] = al; i_disp_al_addr[s] = al; i_disp_payload[s] = {16{al}};
    i_disp_rs1[s] = t1; i_disp_uses_rs1[s] = 1'b1; i_disp_rs1_rdy[s] = rdy1;
    i_disp_rs2[s] = t2; i_disp_uses_rs2[s] = 1'b1; i_disp_rs2_rdy[s] = rdy2;
  endtask

  task automatic set_wb(int p, logic [5:0] t, logic u);
    i_wb_valid[p] = 1'b1; i_wb_uses_rd[p] = u; i_wb_rd[p] = t;
  endtask

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_slot(string nm, int k, logic [5:0] al);
    logic [95:0] pl;
    pl = {16{al}};
    chk({nm, "_al"}, 128'(o_iss_al_addr[k]), 128'(al));
    chk({nm, "_rd"}, 128'(o_iss_rd[k]), 128'(al));
    chk({nm, "_payload"}, 128'(o_iss_payload[k]), 128'(pl));
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("reset_iss_valid", 128'(o_iss_valid), 128'(0));
    chk("reset_stall", 128'(o_stall), 128'(0));

    //             dv    t1a r1a t1b r1b t2 r2 al0 al1 wbv   wbu   wbrd irdy   eiv   st eal0 eal1
    tv.push_back(mk(2'b11, 1, 1,  1,  1,  1, 1, 1,  2,  4'h0, 4'h0, 0,  2'b11, 2'b00, 0, 0,  0));
    tv.push_back(mk(2'b00, 0, 1,  0,  1,  0, 1, 0,  0,  4'h0, 4'h0, 0,  2'b11, 2'b11, 0, 1,  2));
    tv.push_back(mk(2'b00, 0, 1,  0,  1,  0, 1, 0,  0,  4'h0, 4'h0, 0,  2'b11, 2'b00, 0, 0,  0));
    tv.push_back(mk(2'b01, 7, 0,  0,  1,  1, 1, 3,  0,  4'h0, 4'h0, 0,  2'b11, 2'b00, 0, 0,  0));
    tv.push_back(mk(2'b00, 0, 1,  0,  1,  0, 1, 0,  0,  4'h0, 4'h0, 0,  2'b11, 2'b00, 0, 0,  0));
    tv.push_back(mk(2'b00, 0, 1,  0,  1,  0, 1, 0,  0,  4'h0, 4'h0, 0,  2'b11, 2'b00, 0, 0,  0));
    tv.push_back(mk(2'b00, 0, 1,  0,  1,  0, 1, 0,  0,  4'h4, 4'h4, 7,  2'b11, 2'b00, 0, 0,  0));
    tv.push_back(mk(2'b00, 0, 1,  0,  1,  0, 1, 0,  0,  4'h0, 4'h0, 0,  2'b11, 2'b01, 0, 3,  0));
    tv.push_back(mk(2'b01, 1, 1,  0,  1, 12, 0, 4,  0,  4'h1, 4'h1, 12, 2'b11, 2'b00, 0, 0,  0));
    tv.push_back(mk(2'b00, 0, 1,  0,  1,  0, 1, 0,  0,  4'h0, 4'h0, 0,  2'b11, 2'b01, 0, 4,  0));
    tv.push_back(mk(2'b11, 1, 1,  1,  1,  1, 1, 5,  6,  4'h0, 4'h0, 0,  2'b00, 2'b00, 0, 0,  0));
    tv.push_back(mk(2'b00, 0, 1,  0,  1,  0, 1, 0,  0,  4'h0, 4'h0, 0,  2'b00, 2'b11, 0, 5,  6));
    tv.push_back(mk(2'b00, 0, 1,  0,  1,  0, 1, 0,  0,  4'h0, 4'h0, 0,  2'b00, 2'b11, 0, 5,  6));
    tv.push_back(mk(2'b00, 0, 1,  0,  1,  0, 1, 0,  0,  4'h0, 4'h0, 0,  2'b00, 2'b11, 0, 5,  6));
    tv.push_back(mk(2'b00, 0, 1,  0,  1,  0, 1, 0,  0,  4'h0, 4'h0, 0,  2'b11, 2'b11, 0, 5,  6));
    tv.push_back(mk(2'b11, 20,0,  1,  1,  1, 1, 7,  8,  4'h0, 4'h0, 0,  2'b00, 2'b00, 0, 0,  0));
    tv.push_back(mk(2'b00, 0, 1,  0,  1,  0, 1, 0,  0,  4'h8, 4'h8, 20, 2'b00, 2'b01, 0, 8,  0));
    tv.push_back(mk(2'b00, 0, 1,  0,  1,  0, 1, 0,  0,  4'h0, 4'h0, 0,  2'b11, 2'b11, 0, 7,  8));
    tv.push_back(mk(2'b10, 0, 1, 33,  0,  1, 1, 0,  9,  4'h0, 4'h0, 0,  2'b11, 2'b00, 0, 0,  0));
    tv.push_back(mk(2'b00, 0, 1,  0,  1,  0, 1, 0,  0,  4'h2, 4'h0, 33, 2'b11, 2'b00, 0, 0,  0));
    tv.push_back(mk(2'b01, 0, 0,  0,  1,  1, 1, 10, 0,  4'h0, 4'h0, 0,  2'b11, 2'b00, 0, 0,  0));
    tv.push_back(mk(2'b00, 0, 1,  0,  1,  0, 1, 0,  0,  4'h1, 4'h1, 0,  2'b11, 2'b00, 0, 0,  0));
    tv.push_back(mk(2'b00, 0, 1,  0,  1,  0, 1, 0,  0,  4'h2, 4'h2, 33, 2'b11, 2'b01, 0, 10, 0));
    tv.push_back(mk(2'b00, 0, 1,  0,  1,  0, 1, 0,  0,  4'h0, 4'h0, 0,  2'b11, 2'b01, 0, 9,  0));
    tv.push_back(mk(2'b00, 0, 1,  0,  1,  0, 1, 0,  0,  4'h0, 4'h0, 0,  2'b11, 2'b00, 0, 0,  0));

    foreach (tv[r]) begin
      idle();
      if (tv[r].dv[0]) set_slot(0, tv[r].al0, tv[r].t1a, tv[r].r1a, tv[r].t2, tv[r].r2);
      if (tv[r].dv[1]) set_slot(1, tv[r].al1, tv[r].t1b, tv[r].r1b, tv[r].t2, tv[r].r2);
      i_wb_valid   = tv[r].wbv;
      i_wb_uses_rd = tv[r].wbu;
      for (int p = 0; p < 4; p++) i_wb_rd[p] = tv[r].wbrd;
      i_iss_ready  = tv[r].irdy;
      #1;
      chk($sformatf("vec%0d_iss_valid", r), 128'(o_iss_valid), 128'(tv[r].eiv));
      chk($sformatf("vec%0d_stall", r), 128'(o_stall), 128'(tv[r].est));
      if (tv[r].eiv[0]) chk_slot($sformatf("vec%0d_slot0", r), 0, tv[r].eal0);
      if (tv[r].eiv[1]) chk_slot($sformatf("vec%0d_slot1", r), 1, tv[r].eal1);
      step();
    end

    // Fill to 15 entries, each waiting on a unique rs1 tag 40..54.
    for (int p = 0; p < 7; p++) begin
      idle();
      set_slot(0, 6'(32 + 2*p), 6'(40 + 2*p), 1'b0, 6'd1, 1'b1);
      set_slot(1, 6'(33 + 2*p), 6'(41 + 2*p), 1'b0, 6'd1, 1'b1);
      #1;
      chk($sformatf("fill%0d_stall", p), 128'(o_stall), 128'(0));
      step();
    end
    idle();
    set_slot(0, 6'd46, 6'd54, 1'b0, 6'd1, 1'b1);
    #1;
    chk("fill14_stall", 128'(o_stall), 128'(0));
    step();
    idle();
    chk("full_stall", 128'(o_stall), 128'(1));
    chk("full_iss_valid", 128'(o_iss_valid), 128'(0));
    set_slot(0, 6'd60, 6'd1, 1'b1, 6'd1, 1'b1);
    set_slot(1, 6'd61, 6'd1, 1'b1, 6'd1, 1'b1);
    i_iss_ready = 2'b11;
    step();
    idle();
    chk("ignored_disp_iss_valid", 128'(o_iss_valid), 128'(0));
    chk("ignored_disp_stall", 128'(o_stall), 128'(1));
    set_wb(3, 6'd44, 1'b1);
    step();
    idle();
    chk("full_wake_iss_valid", 128'(o_iss_valid), 128'(2'b01));
    chk_slot("full_wake", 0, 6'd36);
    chk("full_wake_stall", 128'(o_stall), 128'(1));
    i_iss_ready = 2'b01;
    step();
    idle();
    chk("after_free_stall", 128'(o_stall), 128'(0));
    chk("after_free_iss_valid", 128'(o_iss_valid), 128'(0));

    // Flush, rebuild a half-full queue, then flush together with dispatch and wakeup.
    i_flush = 1'b1;
    step();
    idle();
    chk("flush1_stall", 128'(o_stall), 128'(0));
    chk("flush1_iss_valid", 128'(o_iss_valid), 128'(0));
    for (int p = 0; p < 3; p++) begin
      idle();
      set_slot(0, 6'(32 + 2*p), 6'(40 + 2*p), 1'b0, 6'd1, 1'b1);
      set_slot(1, 6'(33 + 2*p), 6'(41 + 2*p), 1'b0, 6'd1, 1'b1);
      step();
    end
    idle();
    set_slot(0, 6'd50, 6'd1, 1'b1, 6'd1, 1'b1);
    set_slot(1, 6'd51, 6'd1, 1'b1, 6'd1, 1'b1);
    step();
    idle();
    chk("half_iss_valid", 128'(o_iss_valid), 128'(2'b11));
    chk_slot("half_slot0", 0, 6'd50);
    chk_slot("half_slot1", 1, 6'd51);
    i_flush = 1'b1;
    set_slot(0, 6'd52, 6'd1, 1'b1, 6'd1, 1'b1);
    set_slot(1, 6'd53, 6'd1, 1'b1, 6'd1, 1'b1);
    set_wb(0, 6'd40, 1'b1);
    i_iss_ready = 2'b11;
    step();
    idle();
    chk("flush2_iss_valid", 128'(o_iss_valid), 128'(0));
    chk("flush2_stall", 128'(o_stall), 128'(0));
    step();
    chk("flush2_later_iss_valid", 128'(o_iss_valid), 128'(0));
    set_wb(1, 6'd41, 1'b1);
    step();
    idle();
    chk("flush2_wake_iss_valid", 128'(o_iss_valid), 128'(0));
    set_slot(0, 6'd55, 6'd1, 1'b1, 6'd1, 1'b1);
    step();
    idle();
    chk("post_flush_iss_valid", 128'(o_iss_valid), 128'(2'b01));
    chk_slot("post_flush", 0, 6'd55);
    i_iss_ready = 2'b11;
    step();
    idle();
    chk("post_flush_drain", 128'(o_iss_valid), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_issue_queue.md
Name: int_issue_queue

Overview:
- Sits directly downstream of the rename stage.
- Accepts up to 2 renamed instructions per cycle and holds them until both physical sources are ready.
- Wakes entries on the 4 writeback ports and issues up to 2 ready instructions per cycle, oldest-first, to the execute ports.
- Backpressures rename via o_stall.

Parameters:
- DEPTH, 16, number of queue entries (power of 2, ≥4)
- PREG_W, 6, physical register tag width
- AL_W, 6, active-list index width
- PAYLOAD_W, 96, opaque per-instruction payload (imm, target, uses_imm, control flags) carried unchanged to issue

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_flush  in  1  discard all entries
- i_disp_valid[2]  in  1 each  dispatch slot valid
- i_disp_rd[2]  in  PREG_W  destination tag
- i_disp_rs1[2], i_disp_rs2[2]  in  PREG_W  source tags
- i_disp_uses_rs1[2], i_disp_uses_rs2[2]  in  1  source used
- i_disp_rs1_rdy[2], i_disp_rs2_rdy[2]  in  1  source ready at rename time
- i_disp_al_addr[2]  in  AL_W  active-list index
- i_disp_payload[2]  in  PAYLOAD_W  carried data
- o_stall  out  1  rename must hold its outputs
- i_wb_valid[4], i_wb_uses_rd[4]  in  1  writeback broadcast
- i_wb_rd[4]  in  PREG_W  tag being written
- o_iss_valid[2]  out  1  issue slot valid
- o_iss_rd/rs1/rs2[2]  out  PREG_W
- o_iss_al_addr[2]  out  AL_W
- o_iss_payload[2]  out  PAYLOAD_W
- i_iss_ready[2]  in  1  execute port accepts

Behaviour:
- Clock and reset are as decided: one clock, clk; reset is synchronous and active-high.
- Reset or i_flush at a rising edge clears every entry valid bit and the age matrix. i_flush has priority over dispatch, wakeup and issue in the same cycle. After reset: o_iss_valid=0, o_stall=0.
- Entry state: valid, rs1_rdy, rs2_rdy, tags, al_addr, payload. A source whose uses bit is 0 is stored ready.
- o_stall is combinational: high when free entries < 2.
  - Same-cycle issue frees are not credited.
  - While o_stall=1, i_disp_valid is ignored.
  - Slot 0 and slot 1 are written independently when not stalled; slot 1 may be valid with slot 0 invalid.
- Allocation: lowest-index free entries. Slot 0 takes the lower index.
- Dispatch latency: written at edge N; issuable in cycle N+1.
- Wakeup: a wb port with valid & uses_rd sets the ready bit of every valid entry whose matching source tag equals i_wb_rd. Takes effect at the next edge.
  - Dispatching instructions are compared against same-cycle wb tags, so they are stored ready.
  - Tag 0 wakes like any other tag; rename never allocates tag 0 as a destination.
- Age: DEPTH×DEPTH age matrix. On allocation, the new entry is marked younger than all currently valid entries. Slot 1 is younger than slot 0.
- Select (combinational): ready = valid & rs1_rdy & rs2_rdy.
  - Issue slot 0 gets the oldest ready entry; slot 1 gets the second-oldest.
  - If only one entry is ready, it goes to slot 0.
  - o_iss_* fields come from the selected entry.
- Handshake: an entry is freed at the edge where o_iss_valid[k] & i_iss_ready[k]. Otherwise it stays and is reselected next cycle, possibly on a different slot if an older entry became ready.
- Simultaneous issue-free and dispatch-allocate of the same index in one cycle does not occur, because allocation uses pre-issue free state.
- Full: 15 valid entries → o_stall=1. Empty: o_iss_valid=0.

Optional Feature:
- IQ_PERF_CNT_EN: adds outputs o_stall_cycles (32) and o_issue_count (32).
  - o_stall_cycles increments each cycle o_stall=1.
  - o_issue_count adds the number of handshakes in the cycle (0–2).
  - Both are cleared by reset only, not by flush, and wrap at 2^32.
- Without the macro, neither port nor the counters exist.

Decomposition:
- Shared package core_pkg gains iq_entry_t (valid, rdy bits, tags, al_addr, payload) and constant IQ_DEPTH.
- One sub-module: iq_age_select. Takes the ready vector and the age matrix; returns two one-hot grants, each with a valid bit.

Test Plan:
- Dispatch 2 instructions with all sources ready, i_iss_ready=11 → both issue in cycle N+1, older on slot 0, queue empty at N+2.
- Dispatch one instruction with rs1=7 not ready; wb[2] valid, uses_rd=1, rd=7 at N+3 → o_iss_valid[0] first asserts at N+4.
- Same-cycle race: dispatch rs2=12 not ready while wb[0] rd=12 → instruction issues at N+1.
- Fill to 15 entries with no ready sources → o_stall=1 and further dispatch is ignored. Wake one entry and issue it → o_stall=0 on the following cycle.
- Two ready entries, i_iss_ready=00 for 3 cycles → same outputs are held stable; raising ready drains both in the held order.
- i_flush asserted together with dispatch and wb on a half-full queue → next cycle all invalid, o_stall=0, and no issue occurs from the flushed entries.
